tot_raw_pattern_gen: RTL and testbench

Generates the raw TOT front-end pattern that the TDC TOT encoder consumes: a 21-bit delay-line snapshot plus the two 3-bit ripple-counter values, built from a requested binary {coarse, fine} code. It is the inverse of the TOT encoder. It serves as on-chip self-test stimulus and as the bench driver for encoder regression. It can emit a single code or sweep a code ramp. Every code is held for a programmable dwell, and the intended code is presented alongside for scoreboarding.

---
 rtl/tot_raw_pattern_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_tot_raw_pattern_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tot_raw_pattern_gen.sv
// ---------------------------------------------------------------------------
// tot_raw_pattern_gen
//   Builds the raw TOT front-end pattern (21-tap delay-line snapshot plus the
//   two 3-bit ripple counters) from a binary {coarse, fine} code, i.e. the
//   inverse of the TOT encoder. Emits one code or a code ramp, each held for
//   a programmable dwell, with the intended code presented for scoreboarding.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin operation (sampled only when idle)
//   mode              0 = single code, 1 = sweep
//   code_start        {coarse[8:6], fine[5:0]} first code
//   code_end          {coarse, fine} sweep upper bound
//   step              fine increment per sweep point (0 acts as 1)
//   dwell             cycles each code is held (0 acts as 1)
//   bubble_en         inject one bubble above the thermometer edge
//   A                 raw delay-line pattern
//   counterA/B        ripple counters for positive / negative input
//   code_out          code that produced the current pattern
//   valid             first cycle of each new pattern
//   busy              operation in progress
//   done              one-cycle end-of-operation pulse
//   sat_err           sticky: a fine field above 20 was clamped
// ---------------------------------------------------------------------------
module tot_raw_pattern_gen #(
  parameter int unsigned NTAP    = 21,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [8:0]         code_start,
  input  logic [8:0]         code_end,
  input  logic [3:0]         step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               bubble_en,
  output logic [NTAP-1:0]    A,
  output logic [2:0]         counterA,
  output logic [2:0]         counterB,
  output logic [8:0]         code_out,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic               sat_err
);

  localparam int unsigned CODE_W = 9;
  localparam int unsigned FINE_W = 6;
  localparam int unsigned LIN_W  = 8;

  // Idle delay-line state: alternating taps, bit i = ~i[0]
  localparam logic [NTAP-1:0] ALT = NTAP'(21'h15_5555);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NTAP-1:0]      a_q, a_d;
  logic [2:0]           cnt_a_q, cnt_a_d;
  logic [2:0]           cnt_b_q, cnt_b_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sat_q, sat_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic                 mode_q, mode_d;
  logic [CODE_W-1:0]    end_q, end_d;
  logic [3:0]           step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 bub_q, bub_d;

  // Fine codes above the last tap saturate at the last tap
  function automatic logic [FINE_W-1:0] clamp_fine(input logic [FINE_W-1:0] f);
    return (f > FINE_W'(20)) ? FINE_W'(20) : f;
  endfunction

  // Linear position of a code: coarse*21 + fine
  function automatic logic [LIN_W-1:0] lin(input logic [2:0] c,
                                           input logic [FINE_W-1:0] f);
    return (LIN_W'(c) * LIN_W'(21)) + LIN_W'(f);
  endfunction

  // Thermometer of 'fine' ones XORed onto the alternating background
  function automatic logic [NTAP-1:0] tap_pattern(input logic [FINE_W-1:0] f,
                                                  input logic bub);
    logic [NTAP-1:0] therm;
    therm = (NTAP'(1) << f) - NTAP'(1);
    if (bub && (f < FINE_W'(20))) begin
      therm = therm ^ (NTAP'(1) << (f + FINE_W'(1)));
    end
    return ALT ^ therm;
  endfunction

  // Negative-input counter has already rolled once the edge passes mid-line
  function automatic logic [2:0] counter_b(input logic [2:0] c,
                                           input logic [FINE_W-1:0] f);
    return (f > FINE_W'(10)) ? (c + 3'd1) : c;
  endfunction

  // Next sweep point derived from the currently displayed code
  logic [FINE_W-1:0] fine_sum_c;
  logic              carry_c;
  logic [FINE_W-1:0] nxt_fine_c;
  logic [3:0]        nxt_coarse_c;
  logic              in_range_c;

  always_comb begin
    fine_sum_c   = code_q[5:0] + FINE_W'(step_q);
    carry_c      = fine_sum_c > FINE_W'(20);
    nxt_fine_c   = carry_c ? (fine_sum_c - FINE_W'(21)) : fine_sum_c;
    nxt_coarse_c = {1'b0, code_q[8:6]} + 4'(carry_c);
    in_range_c   = ~nxt_coarse_c[3] &&
                   (lin(nxt_coarse_c[2:0], nxt_fine_c) <= lin(end_q[8:6], end_q[5:0]));
  end

  // Clamped versions of the request, used only at acceptance
  logic [FINE_W-1:0] start_fine_c;
  logic [FINE_W-1:0] end_fine_c;
  logic              clamp_hit_c;

  always_comb begin
    start_fine_c = clamp_fine(code_start[5:0]);
    end_fine_c   = clamp_fine(code_end[5:0]);
    clamp_hit_c  = (code_start[5:0] > FINE_W'(20)) || (code_end[5:0] > FINE_W'(20));
  end

  // Next-state and output logic
  logic              load_c;
  logic [CODE_W-1:0] load_code_c;
  logic              load_bub_c;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sat_d       = sat_q;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    end_d       = end_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    bub_d       = bub_q;
    load_c      = 1'b0;
    load_code_c = code_q;
    load_bub_c  = bub_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          end_d       = {code_end[8:6], end_fine_c};
          step_d      = (step == 4'd0) ? 4'd1 : step;
          dwell_d     = (dwell == '0) ? DWELL_W'(1) : dwell;
          bub_d       = bubble_en;
          sat_d       = clamp_hit_c;
          busy_d      = 1'b1;
          load_c      = 1'b1;
          load_code_c = {code_start[8:6], start_fine_c};
          load_bub_c  = bubble_en;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (dwell_cnt_q >= dwell_q) begin
          if (mode_q && in_range_c) begin
            load_c      = 1'b1;
            load_code_c = {nxt_coarse_c[2:0], nxt_fine_c};
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A freshly loaded code counts as its first dwell cycle
    if (load_c) begin
      a_d         = tap_pattern(load_code_c[5:0], load_bub_c);
      cnt_a_d     = load_code_c[8:6];
      cnt_b_d     = counter_b(load_code_c[8:6], load_code_c[5:0]);
      code_d      = load_code_c;
      valid_d     = 1'b1;
      dwell_cnt_d = DWELL_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= ALT;
      cnt_a_q     <= 3'd0;
      cnt_b_q     <= 3'd0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      dwell_cnt_q <= '0;
      mode_q      <= 1'b0;
      end_q       <= '0;
      step_q      <= 4'd1;
      dwell_q     <= DWELL_W'(1);
      bub_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
      end_q       <= end_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      bub_q       <= bub_d;
    end
  end

  assign A        = a_q;
  assign counterA = cnt_a_q;
  assign counterB = cnt_b_q;
  assign code_out = code_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sat_err  = sat_q;

endmodule

// File: tb/tb_tot_raw_pattern_gen.sv
// Directed bench for tot_raw_pattern_gen. Each check compares the packed
// output vector {A, counterA, counterB, code_out, valid, busy, done, sat_err}
// against a hand-computed value.
module tb_tot_raw_pattern_gen;

  localparam logic [20:0] ALT = 21'h15_5555;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [8:0]  code_start;
  logic [8:0]  code_end;
  logic [3:0]  step;
  logic [7:0]  dwell;
  logic        bubble_en;
  logic [20:0] A;
  logic [2:0]  counterA;
  logic [2:0]  counterB;
  logic [8:0]  code_out;
  logic        valid;
  logic        busy;
  logic        done;
  logic        sat_err;

  int total = 0;
  int bad   = 0;

  logic [39:0] obs;
  logic [39:0] want;

  always #5 clk = ~clk;

  tot_raw_pattern_gen #(.NTAP(21), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .code_start (code_start),
    .code_end   (code_end),
    .step       (step),
    .dwell      (dwell),
    .bubble_en  (bubble_en),
    .A          (A),
    .counterA   (counterA),
    .counterB   (counterB),
    .code_out   (code_out),
    .valid      (valid),
    .busy       (busy),
    .done       (done),
    .sat_err    (sat_err)
  );

  assign obs = {A, counterA, counterB, code_out, valid, busy, done, sat_err};

  function automatic logic [39:0] ex(input logic [20:0] a, input logic [2:0] ca,
                                     input logic [2:0] cb, input logic [8:0] c,
                                     input logic v, input logic b,
                                     input logic d, input logic s);
    return {a, ca, cb, c, v, b, d, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; code_start = 9'h0C7; code_end = 9'h000;
    step = 4'd1; dwell = 8'd1; bubble_en = 1'b0;
    tick(); tick();
    want = ex(ALT, 3'd0, 3'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL reset got=%h want=%h", obs, want); end
    start = 1'b1;
    tick();
    total++; if (obs !== want) begin bad++; $display("FAIL rst_wins got=%h want=%h", obs, want); end
    rst = 1'b0; start = 1'b0;
    tick();
    total++; if (obs !== want) begin bad++; $display("FAIL rst_idle got=%h want=%h", obs, want); end
  endtask

  task automatic test_single();
    code_start = 9'h0C7; mode = 1'b0; dwell = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h7F, 3'd3, 3'd3, 9'h0C7, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL single_first got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h7F, 3'd3, 3'd3, 9'h0C7, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL single_hold1 got=%h want=%h", obs, want); end
    start = 1'b1; code_start = 9'h001;
    tick();
    start = 1'b0; code_start = 9'h0C7;
    total++; if (obs !== want) begin bad++; $display("FAIL start_busy_ignored got=%h want=%h", obs, want); end
    tick();
    total++; if (obs !== want) begin bad++; $display("FAIL single_hold3 got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h7F, 3'd3, 3'd3, 9'h0C7, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL single_done got=%h want=%h", obs, want); end
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h7F, 3'd3, 3'd3, 9'h0C7, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL start_in_done_ignored got=%h want=%h", obs, want); end
    tick();
    total++; if (obs !== want) begin bad++; $display("FAIL single_idle got=%h want=%h", obs, want); end
  endtask

  task automatic test_sweep();
    code_start = 9'h012; code_end = 9'h045; step = 4'd3; dwell = 8'd1; mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h3FFFF, 3'd0, 3'd1, 9'h012, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL sweep_c0 got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT, 3'd1, 3'd1, 9'h040, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL sweep_c1 got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h7, 3'd1, 3'd1, 9'h043, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL sweep_c2 got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h7, 3'd1, 3'd1, 9'h043, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL sweep_done got=%h want=%h", obs, want); end
    tick();
  endtask

  task automatic test_reverse();
    code_start = 9'h045; code_end = 9'h012; step = 4'd1; dwell = 8'd1; mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h1F, 3'd1, 3'd1, 9'h045, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL reverse_c0 got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h1F, 3'd1, 3'd1, 9'h045, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL reverse_done got=%h want=%h", obs, want); end
    tick();
  endtask

  task automatic test_clamp();
    code_start = 9'h0A8; code_end = 9'h000; mode = 1'b0; dwell = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h0F_FFFF, 3'd2, 3'd3, 9'h094, 1'b1, 1'b1, 1'b0, 1'b1);
    total++; if (obs !== want) begin bad++; $display("FAIL clamp_first got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h0F_FFFF, 3'd2, 3'd3, 9'h094, 1'b0, 1'b0, 1'b1, 1'b1);
    total++; if (obs !== want) begin bad++; $display("FAIL clamp_done got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h0F_FFFF, 3'd2, 3'd3, 9'h094, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (obs !== want) begin bad++; $display("FAIL sat_sticky got=%h want=%h", obs, want); end
    code_start = 9'h005; dwell = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h1F, 3'd0, 3'd0, 9'h005, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL sat_cleared got=%h want=%h", obs, want); end
    tick(); tick();
  endtask

  task automatic test_boundary();
    code_start = 9'h1D3; code_end = 9'h1D4; step = 4'd0; dwell = 8'd2; mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h7_FFFF, 3'd7, 3'd0, 9'h1D3, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL bnd_c0_a got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h7_FFFF, 3'd7, 3'd0, 9'h1D3, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL bnd_c0_b got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'hF_FFFF, 3'd7, 3'd0, 9'h1D4, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL bnd_c1_a got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'hF_FFFF, 3'd7, 3'd0, 9'h1D4, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL bnd_c1_b got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'hF_FFFF, 3'd7, 3'd0, 9'h1D4, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL bnd_done got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'hF_FFFF, 3'd7, 3'd0, 9'h1D4, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL bnd_idle got=%h want=%h", obs, want); end
    step = 4'd1;
  endtask

  task automatic test_bubble();
    code_start = 9'h005; code_end = 9'h000; mode = 1'b0; dwell = 8'd1; bubble_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h1F ^ 21'h40, 3'd0, 3'd0, 9'h005, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL bubble_f5 got=%h want=%h", obs, want); end
    tick(); tick();
    code_start = 9'h014;
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'hF_FFFF, 3'd0, 3'd1, 9'h014, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL bubble_f20 got=%h want=%h", obs, want); end
    tick(); tick();
    bubble_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    code_start = 9'h000; code_end = 9'h140; step = 4'd1; dwell = 8'd3; mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    want = ex(ALT ^ 21'h1, 3'd0, 3'd0, 9'h001, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL mid_second_code got=%h want=%h", obs, want); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    want = ex(ALT, 3'd0, 3'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL rst_mid got=%h want=%h", obs, want); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (obs !== want) begin bad++; $display("FAIL rst_mid_quiet%0d got=%h want=%h", i, obs, want); end
    end
    code_start = 9'h0C7; mode = 1'b0; dwell = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    want = ex(ALT ^ 21'h7F, 3'd3, 3'd3, 9'h0C7, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL restart got=%h want=%h", obs, want); end
    tick();
    want = ex(ALT ^ 21'h7F, 3'd3, 3'd3, 9'h0C7, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (obs !== want) begin bad++; $display("FAIL restart_done got=%h want=%h", obs, want); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_reverse();
    test_clamp();
    test_boundary();
    test_bubble();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
